// File: rtl/reg_native_master.sv
// rtl/reg_native_master.sv - reg_native initiator: one command in, one request out, one response back
// Single-outstanding FSM with an optional saturating acknowledge timeout.
module reg_native_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  req_vld,
  input  logic                  req_rdy,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  ack_vld,
  output logic                  ack_rdy,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RSP} state_t;

  state_t        state;
  logic [CW-1:0] tmo_cnt;
  logic [CW-1:0] tmo_nxt;
  logic          tmo_hit;

  assign cmd_rdy = (state == IDLE);
  assign rsp_vld = (state == RSP);

  // Timeout fires on the edge where the count would reach TIMEOUT; a handshake on that edge wins.
  always_comb begin
    tmo_nxt = (tmo_cnt == CW'(TIMEOUT)) ? tmo_cnt : tmo_cnt + CW'(1);
    tmo_hit = (TIMEOUT > 0) && (tmo_nxt == CW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_vld   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      ack_rdy   <= 1'b0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      tmo_cnt   <= '0;
    end else begin
      ack_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_vld) begin
            state     <= REQ;
            req_vld   <= 1'b1;
            wr_en     <= cmd_wr;
            rd_en     <= ~cmd_wr;
            addr      <= cmd_addr;
            wr_data   <= cmd_wdata;
            rsp_wr    <= cmd_wr;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_nxt;
          if (req_rdy) begin
            state   <= WAIT_ACK;
            req_vld <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
          end else if (tmo_hit) begin
            state     <= RSP;
            req_vld   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        WAIT_ACK: begin
          tmo_cnt <= tmo_nxt;
          if (ack_vld) begin
            state     <= RSP;
            ack_rdy   <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rsp_wr ? '0 : rd_data;
          end else if (tmo_hit) begin
            state     <= RSP;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        RSP: begin
          if (rsp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_native_master.sv
// tb/tb_reg_native_master.sv - directed bench for reg_native_master
// Instance a uses TIMEOUT=8, instance b uses TIMEOUT=4 for the late-acknowledge case.
module tb_reg_native_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_cmd_vld, a_cmd_rdy, a_cmd_wr;
  logic [5:0]  a_cmd_addr, a_addr;
  logic [31:0] a_cmd_wdata, a_wr_data, a_rd_data, a_rsp_rdata;
  logic        a_req_vld, a_req_rdy, a_wr_en, a_rd_en, a_ack_vld, a_ack_rdy;
  logic        a_rsp_vld, a_rsp_rdy, a_rsp_wr, a_rsp_err;

  logic        b_cmd_vld, b_cmd_rdy, b_cmd_wr;
  logic [5:0]  b_cmd_addr, b_addr;
  logic [31:0] b_cmd_wdata, b_wr_data, b_rd_data, b_rsp_rdata;
  logic        b_req_vld, b_req_rdy, b_wr_en, b_rd_en, b_ack_vld, b_ack_rdy;
  logic        b_rsp_vld, b_rsp_rdy, b_rsp_wr, b_rsp_err;

  reg_native_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(a_cmd_vld), .cmd_rdy(a_cmd_rdy), .cmd_wr(a_cmd_wr),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
    .req_vld(a_req_vld), .req_rdy(a_req_rdy), .wr_en(a_wr_en), .rd_en(a_rd_en),
    .addr(a_addr), .wr_data(a_wr_data), .rd_data(a_rd_data),
    .ack_vld(a_ack_vld), .ack_rdy(a_ack_rdy),
    .rsp_vld(a_rsp_vld), .rsp_rdy(a_rsp_rdy), .rsp_wr(a_rsp_wr),
    .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata)
  );

  reg_native_master #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(b_cmd_vld), .cmd_rdy(b_cmd_rdy), .cmd_wr(b_cmd_wr),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .req_vld(b_req_vld), .req_rdy(b_req_rdy), .wr_en(b_wr_en), .rd_en(b_rd_en),
    .addr(b_addr), .wr_data(b_wr_data), .rd_data(b_rd_data),
    .ack_vld(b_ack_vld), .ack_rdy(b_ack_rdy),
    .rsp_vld(b_rsp_vld), .rsp_rdy(b_rsp_rdy), .rsp_wr(b_rsp_wr),
    .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_cmd_vld = 0; a_cmd_wr = 0; a_cmd_addr = '0; a_cmd_wdata = '0;
    a_req_rdy = 0; a_ack_vld = 0; a_rsp_rdy = 0; a_rd_data = '0;
    b_cmd_vld = 0; b_cmd_wr = 0; b_cmd_addr = '0; b_cmd_wdata = '0;
    b_req_rdy = 0; b_ack_vld = 0; b_rsp_rdy = 0; b_rd_data = '0;
    tick(); tick();
    chk("reset_a", {a_cmd_rdy, a_req_vld, a_wr_en, a_rd_en, a_ack_rdy, a_rsp_vld,
                    a_rsp_wr, a_rsp_err, a_addr, a_wr_data, a_rsp_rdata}, {1'b1, 77'd0});
    rst_n = 1'b1;
    tick();
    chk("idle_a", {a_cmd_rdy, a_req_vld, a_rsp_vld}, 3'b100);

    // Write 0x05 <- DEADBEEF, minimum latency; stray ack_vld in IDLE/REQ must be ignored.
    a_cmd_vld = 1; a_cmd_wr = 1; a_cmd_addr = 6'h05; a_cmd_wdata = 32'hDEADBEEF;
    a_req_rdy = 1; a_ack_vld = 1; a_rd_data = 32'h12345678;
    tick();
    chk("wr_req", {a_cmd_rdy, a_req_vld, a_wr_en, a_rd_en, a_ack_rdy, a_addr, a_wr_data},
        {5'b01100, 6'h05, 32'hDEADBEEF});
    a_cmd_vld = 0;
    tick();
    chk("wr_wait", {a_req_vld, a_wr_en, a_rd_en, a_ack_rdy, a_rsp_vld, a_addr}, {5'b00000, 6'h05});
    tick();
    chk("wr_rsp", {a_rsp_vld, a_ack_rdy, a_rsp_wr, a_rsp_err, a_rsp_rdata}, {4'b1110, 32'h0});
    a_ack_vld = 0; a_rsp_rdy = 1;
    tick();
    chk("wr_done", {a_rsp_vld, a_cmd_rdy, a_ack_rdy}, 3'b010);
    a_rsp_rdy = 0;

    // Read 0x05, then hold the response under backpressure with a pending command.
    a_cmd_vld = 1; a_cmd_wr = 0; a_cmd_addr = 6'h05; a_rd_data = 32'hDEADBEEF;
    tick();
    chk("rd_req", {a_req_vld, a_wr_en, a_rd_en, a_addr}, {3'b101, 6'h05});
    a_cmd_vld = 0; a_ack_vld = 1;
    tick();
    chk("rd_wait", {a_req_vld, a_rd_en, a_rsp_vld}, 3'b000);
    tick();
    chk("rd_rsp", {a_rsp_vld, a_ack_rdy, a_rsp_wr, a_rsp_err, a_rsp_rdata}, {4'b1100, 32'hDEADBEEF});
    a_ack_vld = 0; a_rd_data = 32'h0BADF00D;
    a_cmd_vld = 1; a_cmd_wr = 1; a_cmd_addr = 6'h2A; a_cmd_wdata = 32'hA5A50F0F;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold", {a_rsp_vld, a_rsp_err, a_rsp_wr, a_cmd_rdy, a_req_vld, a_ack_rdy, a_rsp_rdata},
          {6'b100000, 32'hDEADBEEF});
    end
    a_rsp_rdy = 1;
    tick();
    chk("bp_release", {a_rsp_vld, a_cmd_rdy, a_req_vld}, 3'b010);
    a_rsp_rdy = 0; a_req_rdy = 0;

    // Pending command accepted one edge later; req_rdy at accept+3, ack_vld at accept+8 (ties timeout).
    tick();
    chk("hs_accept", {a_req_vld, a_wr_en, a_rd_en, a_addr, a_wr_data}, {3'b110, 6'h2A, 32'hA5A50F0F});
    a_cmd_vld = 0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("hs_req_hold", {a_req_vld, a_wr_en, a_rd_en, a_rsp_vld, a_addr, a_wr_data},
          {4'b1100, 6'h2A, 32'hA5A50F0F});
    end
    a_req_rdy = 1;
    tick();
    chk("hs_req_done", {a_req_vld, a_wr_en, a_rd_en, a_addr, a_wr_data}, {3'b000, 6'h2A, 32'hA5A50F0F});
    a_req_rdy = 0;
    for (int i = 4; i <= 7; i++) begin
      tick();
      chk("hs_wait", {a_rsp_vld, a_ack_rdy, a_req_vld}, 3'b000);
    end
    a_ack_vld = 1;
    tick();
    chk("hs_ack_wins", {a_rsp_vld, a_ack_rdy, a_rsp_err, a_rsp_wr, a_rsp_rdata}, {4'b1101, 32'h0});
    a_ack_vld = 0; a_rsp_rdy = 1;
    tick();
    chk("hs_ack_pulse", {a_ack_rdy, a_rsp_vld, a_cmd_rdy}, 3'b001);
    a_rsp_rdy = 0;

    // Timeout: req_rdy never asserted, error exactly 8 edges after accept.
    a_cmd_vld = 1; a_cmd_wr = 0; a_cmd_addr = 6'h3F; a_rd_data = 32'hFFFF0000;
    tick();
    a_cmd_vld = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("tmo_pending", {a_rsp_vld, a_req_vld, a_rd_en}, 3'b011);
    end
    tick();
    chk("tmo_fire", {a_rsp_vld, a_rsp_err, a_req_vld, a_rd_en, a_wr_en, a_rsp_rdata}, {5'b11000, 32'h0});
    a_rsp_rdy = 1;
    tick();
    chk("tmo_done", {a_rsp_vld, a_cmd_rdy}, 2'b01);
    a_rsp_rdy = 0;

    // Asynchronous reset while in WAIT_ACK.
    a_cmd_vld = 1; a_cmd_wr = 1; a_cmd_addr = 6'h11; a_cmd_wdata = 32'h55AA55AA; a_req_rdy = 1;
    tick();
    a_cmd_vld = 0;
    tick();
    chk("rst_pre", {a_req_vld, a_rsp_vld, a_cmd_rdy, a_addr}, {3'b000, 6'h11});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {a_cmd_rdy, a_req_vld, a_wr_en, a_rd_en, a_ack_rdy, a_rsp_vld,
                      a_rsp_wr, a_rsp_err, a_addr, a_wr_data, a_rsp_rdata}, {1'b1, 77'd0});
    a_req_rdy = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_after", {a_cmd_rdy, a_req_vld, a_rsp_vld}, 3'b100);

    // Late acknowledge on the TIMEOUT=4 instance.
    b_cmd_vld = 1; b_cmd_wr = 0; b_cmd_addr = 6'h07; b_req_rdy = 1; b_rd_data = 32'hCAFEF00D;
    tick();
    b_cmd_vld = 0;
    tick();
    chk("late_wait", {b_req_vld, b_rsp_vld}, 2'b00);
    for (int i = 2; i <= 3; i++) begin
      tick();
      chk("late_pending", {b_rsp_vld, b_ack_rdy}, 2'b00);
    end
    tick();
    chk("late_err", {b_rsp_vld, b_rsp_err, b_rsp_wr, b_rsp_rdata}, {3'b110, 32'h0});
    tick();
    b_ack_vld = 1;
    tick();
    chk("late_ack_ignored", {b_ack_rdy, b_rsp_vld, b_rsp_err, b_rsp_rdata}, {3'b011, 32'h0});
    b_rsp_rdy = 1;
    tick();
    chk("late_idle", {b_ack_rdy, b_rsp_vld, b_cmd_rdy}, 3'b001);
    b_ack_vld = 0; b_rsp_rdy = 0;
    b_cmd_vld = 1;
    tick();
    b_cmd_vld = 0; b_ack_vld = 1;
    tick();
    tick();
    chk("late_next_ok", {b_rsp_vld, b_ack_rdy, b_rsp_err, b_rsp_wr, b_rsp_rdata}, {4'b1100, 32'hCAFEF00D});
    b_ack_vld = 0; b_rsp_rdy = 1;
    tick();
    chk("late_next_done", {b_rsp_vld, b_cmd_rdy, b_ack_rdy}, 3'b010);
    b_rsp_rdy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
